alu_chromosome_gen: RTL and testbench

Synthesizable ALU stimulus generator for hardware-accelerated HAVEN runs. It is the consumer of a GA chromosome: it takes one chromosome's ranges (operand A/B, inter-transaction delay, enabled operand-B sources) plus a transaction count. It then emits that many pseudo-random ALU transactions on a valid/ready interface to the ALU DUT input port, and signals completion so the GA can score the chromosome.

---
 rtl/sv_alu_gen_pkg.sv | 49 ++++
 rtl/alu_gen_lfsr.sv | 47 ++++
 rtl/alu_chromosome_gen.sv | 163 ++++++++++++++++
 tb/tb_alu_chromosome_gen.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sv_alu_gen_pkg.sv
`default_nettype none
// ============================================================================
// sv_alu_gen_pkg : state, MOVI encodings, LFSR constants and range mapping
// Rev 1.0
// ============================================================================
package sv_alu_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_SEND = 2'd3
  } gen_state_e;

  localparam logic [1:0] MOVI_REG = 2'b00;
  localparam logic [1:0] MOVI_MEM = 2'b01;
  localparam logic [1:0] MOVI_IMM = 2'b10;

  localparam int                    LFSR_WIDTH = 32;
  localparam logic [LFSR_WIDTH-1:0] LFSR_POLY  = 32'h8020_0003;

  // Scales the low w bits of r onto [lo, hi]; the span needs one extra bit for a full range.
  function automatic logic [7:0] map_range(input logic [7:0] r, input logic [7:0] lo,
                                           input logic [7:0] hi, input int w);
    logic [7:0]  mask;
    logic [8:0]  span;
    logic [16:0] prod;
    mask = 8'((9'd1 << w) - 9'd1);
    span = {1'b0, hi} - {1'b0, lo} + 9'd1;
    prod = {9'd0, r & mask} * {8'd0, span};
    if (lo > hi) return lo;
    return lo + 8'(prod >> w);
  endfunction

  function automatic logic [1:0] pick_movi(input logic [1:0] raw, input logic [2:0] en);
    logic [1:0] c;
    logic [1:0] o1;
    logic [1:0] o2;
    c  = (raw == 2'd3) ? MOVI_REG : raw;
    o1 = (c == MOVI_IMM) ? MOVI_REG : c + 2'd1;
    o2 = (o1 == MOVI_IMM) ? MOVI_REG : o1 + 2'd1;
    if (en[c])  return c;
    if (en[o1]) return o1;
    if (en[o2]) return o2;
    return MOVI_REG;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_gen_lfsr.sv
`default_nettype none
// ============================================================================
// alu_gen_lfsr : 32-bit Galois LFSR with synchronous load and step enable
// Rev 1.0
// ============================================================================
module alu_gen_lfsr
  import sv_alu_gen_pkg::*;
#(
  parameter logic [LFSR_WIDTH-1:0] SEED = 32'h0000_0001
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic                  en_i,
  output logic [LFSR_WIDTH-1:0] state_o
);

  logic [LFSR_WIDTH-1:0] state_q;
  logic [LFSR_WIDTH-1:0] state_d;

  generate
    if (SEED == '0) begin : g_seed_check
      $error("alu_gen_lfsr: SEED must be nonzero");
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = SEED;
    end else if (en_i) begin
      state_d = (state_q >> 1) ^ (state_q[0] ? LFSR_POLY : '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule
`default_nettype wire

// File: rtl/alu_chromosome_gen.sv
`default_nettype none
// ============================================================================
// alu_chromosome_gen : emits TRANS_COUNT pseudo-random ALU transactions from one GA chromosome
// Rev 1.0
// ============================================================================
module alu_chromosome_gen
  import sv_alu_gen_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [LFSR_WIDTH-1:0] SEED       = 32'h0000_0001
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [15:0]           trans_count_i,
  input  logic [DATA_WIDTH-1:0] a_min_i,
  input  logic [DATA_WIDTH-1:0] a_max_i,
  input  logic [DATA_WIDTH-1:0] b_min_i,
  input  logic [DATA_WIDTH-1:0] b_max_i,
  input  logic [7:0]            delay_min_i,
  input  logic [7:0]            delay_max_i,
  input  logic [2:0]            movi_en_i,
  input  logic                  alu_rdy_i,
  output logic                  act_o,
  output logic [3:0]            op_o,
  output logic [1:0]            movi_o,
  output logic [DATA_WIDTH-1:0] reg_a_o,
  output logic [DATA_WIDTH-1:0] oper_b_o,
  output logic                  busy_o,
  output logic                  done_o
);

  generate
    if (DATA_WIDTH < 1 || DATA_WIDTH > 8) begin : g_width_check
      $error("alu_chromosome_gen: DATA_WIDTH must be 1..8");
    end
  endgenerate

  gen_state_e            state_q;
  logic [15:0]           remain_q;
  logic [7:0]            wait_q;
  logic [DATA_WIDTH-1:0] a_min_q, a_max_q, b_min_q, b_max_q;
  logic [7:0]            dly_min_q, dly_max_q;
  logic [2:0]            movi_en_q;
  logic                  act_q, busy_q, done_q;
  logic [3:0]            op_q;
  logic [1:0]            movi_q;
  logic [DATA_WIDTH-1:0] reg_a_q, oper_b_q;

  logic [LFSR_WIDTH-1:0] lfsr_w;
  logic                  lfsr_load_w;
  logic [DATA_WIDTH-1:0] a_val_w, b_val_w;
  logic [7:0]            dly_w;
  logic [1:0]            movi_w;
  logic                  unused_lfsr_w;

  assign lfsr_load_w = (state_q == ST_IDLE) && start_i;

  alu_gen_lfsr #(
    .SEED(SEED)
  ) u_lfsr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (lfsr_load_w),
    .en_i   (busy_q),
    .state_o(lfsr_w)
  );

  // Field extraction from the current LFSR word, consumed only in GEN.
  assign a_val_w       = DATA_WIDTH'(map_range(lfsr_w[7:0], 8'(a_min_q), 8'(a_max_q), DATA_WIDTH));
  assign b_val_w       = DATA_WIDTH'(map_range(lfsr_w[15:8], 8'(b_min_q), 8'(b_max_q), DATA_WIDTH));
  assign dly_w         = map_range(lfsr_w[23:16], dly_min_q, dly_max_q, 8);
  assign movi_w        = pick_movi(lfsr_w[29:28], movi_en_q);
  assign unused_lfsr_w = ^lfsr_w[31:30];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      remain_q  <= '0;
      wait_q    <= '0;
      a_min_q   <= '0;
      a_max_q   <= '0;
      b_min_q   <= '0;
      b_max_q   <= '0;
      dly_min_q <= '0;
      dly_max_q <= '0;
      movi_en_q <= '0;
      act_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      op_q      <= '0;
      movi_q    <= MOVI_REG;
      reg_a_q   <= '0;
      oper_b_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            a_min_q   <= a_min_i;
            a_max_q   <= a_max_i;
            b_min_q   <= b_min_i;
            b_max_q   <= b_max_i;
            dly_min_q <= delay_min_i;
            dly_max_q <= delay_max_i;
            movi_en_q <= movi_en_i;
            remain_q  <= trans_count_i;
            if (trans_count_i == 16'd0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= ST_GEN;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_GEN: begin
          op_q     <= lfsr_w[27:24];
          movi_q   <= movi_w;
          reg_a_q  <= a_val_w;
          oper_b_q <= b_val_w;
          if (dly_w == 8'd0) begin
            state_q <= ST_SEND;
            act_q   <= 1'b1;
          end else begin
            wait_q  <= dly_w;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          wait_q <= wait_q - 8'd1;
          if (wait_q == 8'd1) begin
            state_q <= ST_SEND;
            act_q   <= 1'b1;
          end
        end
        ST_SEND: begin
          if (alu_rdy_i) begin
            act_q    <= 1'b0;
            remain_q <= remain_q - 16'd1;
            if (remain_q == 16'd1) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_GEN;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign act_o    = act_q;
  assign op_o     = op_q;
  assign movi_o   = movi_q;
  assign reg_a_o  = reg_a_q;
  assign oper_b_o = oper_b_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_chromosome_gen.sv
`default_nettype none
// ============================================================================
// tb_alu_chromosome_gen : directed and randomized checks against a transaction-level model
// Rev 1.0
// ============================================================================
module tb_alu_chromosome_gen;

  localparam int          DW   = 8;
  localparam logic [31:0] SEED = 32'h0000_0001;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [15:0]   trans_count;
  logic [DW-1:0] a_min, a_max, b_min, b_max;
  logic [7:0]    delay_min, delay_max;
  logic [2:0]    movi_en;
  logic          alu_rdy;
  logic          act, busy, done;
  logic [3:0]    op;
  logic [1:0]    movi;
  logic [DW-1:0] reg_a, oper_b;

  alu_chromosome_gen #(.DATA_WIDTH(DW), .SEED(SEED)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .trans_count_i(trans_count),
    .a_min_i(a_min), .a_max_i(a_max), .b_min_i(b_min), .b_max_i(b_max),
    .delay_min_i(delay_min), .delay_max_i(delay_max), .movi_en_i(movi_en),
    .alu_rdy_i(alu_rdy), .act_o(act), .op_o(op), .movi_o(movi),
    .reg_a_o(reg_a), .oper_b_o(oper_b), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int c_amin, c_amax, c_bmin, c_bmax, c_dmin, c_dmax, c_en;
  int act_cycles[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain integer arithmetic on the chromosome rules.
  function automatic int m_map(input int r, input int lo, input int hi, input int w);
    int m;
    m = 1 << w;
    if (lo > hi) return lo;
    return lo + ((r % m) * (hi - lo + 1)) / m;
  endfunction

  function automatic int m_movi(input int raw, input int en);
    int c;
    c = raw % 3;
    for (int k = 0; k < 3; k++) begin
      if (((en >> ((c + k) % 3)) & 1) == 1) return (c + k) % 3;
    end
    return 0;
  endfunction

  function automatic logic [31:0] m_adv(input logic [31:0] r, input int n);
    logic [31:0] x;
    x = r;
    for (int i = 0; i < n; i++) x = x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
    return x;
  endfunction

  task automatic set_cfg(input int amin, input int amax, input int bmin, input int bmax,
                         input int dmin, input int dmax, input int en);
    c_amin = amin; c_amax = amax; c_bmin = bmin; c_bmax = bmax;
    c_dmin = dmin; c_dmax = dmax; c_en = en;
  endtask

  // Runs one chromosome; transaction stall_txn is held in SEND for stall_len cycles.
  task automatic run(input int n, input int stall_txn, input int stall_len);
    logic [31:0] r;
    int cyc, gen_cyc, hs, dones, send_cycles, stall_left, budget;
    int ea, eb, ed, eop, emv;
    bit in_act;
    r = SEED;
    act_cycles.delete();
    a_min = DW'(c_amin); a_max = DW'(c_amax); b_min = DW'(c_bmin); b_max = DW'(c_bmax);
    delay_min = 8'(c_dmin); delay_max = 8'(c_dmax); movi_en = 3'(c_en);
    trans_count = 16'(n); alu_rdy = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    // Config changes after acceptance must be ignored.
    a_min = DW'($urandom); a_max = DW'($urandom); b_min = DW'($urandom); b_max = DW'($urandom);
    delay_min = 8'($urandom); delay_max = 8'($urandom); movi_en = 3'($urandom);
    trans_count = 16'($urandom);
    cyc = 1; gen_cyc = 1; hs = 0; dones = 0; in_act = 1'b0;
    send_cycles = 0; stall_left = 0; ea = 0; eb = 0; ed = 0; eop = 0; emv = 0;
    budget = n * (260 + stall_len) + 10;
    while (hs < n && cyc < budget) begin
      dones += int'(done);
      if (act) begin
        if (!in_act) begin
          ea  = m_map(int'(r[7:0]),   c_amin, c_amax, DW);
          eb  = m_map(int'(r[15:8]),  c_bmin, c_bmax, DW);
          ed  = m_map(int'(r[23:16]), c_dmin, c_dmax, 8);
          eop = int'(r[27:24]);
          emv = m_movi(int'(r[29:28]), c_en);
          chk("act_cycle", 32'(cyc), 32'(gen_cyc + 1 + ed));
          act_cycles.push_back(cyc);
          in_act = 1'b1;
          send_cycles = 0;
          stall_left = (hs == stall_txn) ? stall_len : 0;
        end
        chk("reg_a", 32'(reg_a), 32'(ea));
        chk("oper_b", 32'(oper_b), 32'(eb));
        chk("op", 32'(op), 32'(eop));
        chk("movi", 32'(movi), 32'(emv));
        chk("busy_in_send", 32'(busy), 32'd1);
        if (c_amin <= c_amax) chk("a_range", 32'(int'(reg_a) >= c_amin && int'(reg_a) <= c_amax), 32'd1);
        send_cycles++;
        if (stall_left > 0) begin
          alu_rdy = 1'b0;
          start = 1'(stall_left % 2);
          stall_left--;
        end else begin
          alu_rdy = 1'b1;
          start = 1'b0;
          hs++;
          in_act = 1'b0;
          r = m_adv(r, 1 + ed + send_cycles);
          gen_cyc = cyc + 1;
        end
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    alu_rdy = 1'b1;
    chk("handshakes", 32'(hs), 32'(n));
    chk("early_done", 32'(dones), 32'd0);
    chk("done_pulse", 32'(done), 32'd1);
    chk("act_after_last", 32'(act), 32'd0);
    chk("busy_after_last", 32'(busy), 32'd0);
    tick();
    chk("done_single", 32'(done), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; alu_rdy = 1'b1; trans_count = '0;
    a_min = '0; a_max = '0; b_min = '0; b_max = '0;
    delay_min = '0; delay_max = '0; movi_en = '0;
    repeat (3) tick();
    chk("rst_act", 32'(act), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_op", 32'(op), 32'd0);
    chk("rst_movi", 32'(movi), 32'd0);
    chk("rst_reg_a", 32'(reg_a), 32'd0);
    chk("rst_oper_b", 32'(oper_b), 32'd0);
    rst_n = 1'b1;
    tick();

    // Fixed ranges, single transaction.
    set_cfg(8'h3C, 8'h3C, 8'hA5, 8'hA5, 0, 0, 3'b100);
    run(1, -1, 0);
    chk("fixed_act_t2", 32'(act_cycles.size() == 1 ? act_cycles[0] : -1), 32'd2);

    // Zero transaction count.
    trans_count = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    chk("zero_act", 32'(act), 32'd0);
    tick();
    chk("zero_done_end", 32'(done), 32'd0);
    chk("zero_act_end", 32'(act), 32'd0);

    // Fixed delay of 3: ACT spacing of 5 cycles.
    set_cfg(0, 255, 0, 255, 3, 3, 3'b111);
    run(4, -1, 0);
    chk("delay3_count", 32'(act_cycles.size()), 32'd4);
    for (int i = 1; i < act_cycles.size(); i++)
      chk("delay3_spacing", 32'(act_cycles[i] - act_cycles[i-1]), 32'd5);

    // Long random-stream run, memory source only.
    set_cfg(10, 20, 0, 255, 0, 1, 3'b010);
    run(1000, -1, 0);

    // Stall in SEND for 7 cycles with START pulses.
    set_cfg(5, 200, 17, 90, 0, 2, 3'b011);
    run(3, 1, 7);

    // Reset during WAIT, then a fresh run.
    set_cfg(0, 255, 0, 255, 5, 5, 3'b001);
    trans_count = 16'd3; delay_min = 8'd5; delay_max = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("rstwait_busy", 32'(busy), 32'd0);
    chk("rstwait_act", 32'(act), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("rstwait_idle_busy", 32'(busy), 32'd0);
    run(3, -1, 0);

    // Randomized chromosomes, including inverted ranges and arbitrary source masks.
    for (int t = 0; t < 6; t++) begin
      set_cfg(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 7)));
      run(int'($urandom_range(1, 30)), int'($urandom_range(0, 3)), int'($urandom_range(0, 5)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
